uart_rx_param: RTL
==================

Name: uart_rx_param

Overview:
- Parametrised UART receiver; successor to the fixed 8N1 receiver.
- Oversamples the serial line at OVERSAMPLE clocks per bit and uses 3-sample majority voting at mid-bit.
- Supports 5–9 data bits, optional even/odd parity and 1 or 2 stop bits, all received LSB first.
- Delivers each frame to downstream logic through a one-entry valid/ready holding register with error and overrun status.

Parameters:
- OVERSAMPLE, 16: clocks per bit; even, range 8..64.
- DATA_BITS, 8: data bits per frame, 5..9.
- PARITY_EN, 0: 1 = a parity bit follows the data.
- PARITY_ODD, 0: 1 = odd parity, 0 = even parity; ignored when PARITY_EN = 0.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- s_clk_i  in  1  sample clock, OVERSAMPLE × baud.
- rst_ni  in  1  reset; asynchronous, active-low.
- rx_i  in  1  serial line; asynchronous, idles high.
- data_o  out  DATA_BITS  received word; bit 0 is the first bit received.
- frame_err_o  out  1  stop bit sampled 0; qualified by data_valid_o.
- parity_err_o  out  1  parity mismatch; qualified by data_valid_o.
- data_valid_o  out  1  holding register full.
- data_ready_i  in  1  consumer accepts the word when data_valid_o is also high.
- overrun_o  out  1  one-cycle pulse when a completed frame is dropped.
- busy_o  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; synchroniser flops 1.
- Input synchroniser: rx_i passes through a 2-flop synchroniser (output rx_s) before any use, so every line edge reaches the FSM 2 clocks late.
- Sample counter cnt:
  - width $clog2(OVERSAMPLE); runs 0..OVERSAMPLE-1 and wraps to 0.
  - held at 0 in IDLE and WAIT_HIGH.
- Bit decision:
  - rx_s is captured at cnt = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - The bit value is the majority of the three and is taken at cnt = OVERSAMPLE/2+1 (the "decision cycle").
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: rx_s = 0 → START; cnt restarts at 0 on the first low cycle.
  - START, at the decision cycle:
    - majority 1 → IDLE (glitch rejected, nothing output);
    - otherwise remain in START until cnt wraps, then → DATA.
  - DATA:
    - each decision shifts the bit into a DATA_BITS-wide shift register from the MSB side, so the first bit received ends in bit 0;
    - the bit index increments on each wrap;
    - after DATA_BITS bits, at the wrap → PARITY if PARITY_EN, else → STOP.
  - PARITY:
    - the decision bit is XORed with the XOR of the data bits;
    - parity error when the result ≠ PARITY_ODD;
    - at the wrap → STOP.
  - STOP:
    - each stop-bit decision ORs (!bit) into the framing-error accumulator;
    - on the decision of the last stop bit the frame completes;
    - the FSM does not wait for the wrap: → IDLE if the bit is 1, → WAIT_HIGH if it is 0.
    - With STOP_BITS = 2, the first stop bit runs to its wrap before the second is sampled.
  - WAIT_HIGH: stays until rx_s = 1, then → IDLE. A break condition therefore produces exactly one frame.
- Frame completion, in the cycle after the last stop decision:
  - If data_valid_o = 0, or data_valid_o = 1 and data_ready_i = 1 in that same cycle: load data_o, frame_err_o and parity_err_o, and set data_valid_o.
  - Otherwise: overrun_o pulses for 1 cycle, the new frame is discarded and the held word is unchanged.
- Handshake:
  - data_valid_o falls in the cycle after data_valid_o & data_ready_i unless a new load happens in that cycle.
  - data_o and the error flags stay stable while data_valid_o is high and the word has not been accepted.
  - data_ready_i has no effect while data_valid_o = 0.
- Latency: from the line edge at the start of the start bit to data_valid_o rising = 2 + (1 + DATA_BITS + PARITY_EN + STOP_BITS - 1) × OVERSAMPLE + OVERSAMPLE/2 + 2 clocks, ±1 for the asynchronous edge.
- Back-to-back frames: a new start edge is detected in IDLE immediately after the stop decision, which tolerates up to ~OVERSAMPLE/2 clocks of baud mismatch.
- Reset mid-frame: returns to IDLE at once; the partial frame is lost and no flags are raised.

Decomposition:
- Package uart_pkg holds:
  - typedef enum rx_state_t {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH};
  - localparams for parity mode (PAR_EVEN = 0, PAR_ODD = 1);
  - a function that computes the counter width from OVERSAMPLE.
- One sub-module, uart_rx_sampler, contains the 2-flop synchroniser, the three-tap capture and the majority output. Its ports are s_clk_i, rst_ni, rx_i, cnt, rx_s_o and bit_o.

Test Plan:
- 8N1, OVERSAMPLE = 16, 10 ns clock (160 ns/bit); send 0xA5 LSB first with data_ready_i held 1 → data_o = 0xA5, both error flags 0, data_valid_o high for 1 cycle.
- 60 ns low pulse on the idle line (shorter than half a bit) → back to IDLE, busy_o drops, no data_valid_o.
- PARITY_EN = 1, PARITY_ODD = 0; send 0x07 with parity bit 1, then 0x07 with parity bit 0 → first word has parity_err_o = 0, second has parity_err_o = 1.
- data_ready_i held 0; send 0x3C then 0xC3 back-to-back → data_o holds 0x3C, overrun_o pulses once when the second frame completes; raising data_ready_i clears data_valid_o one cycle later.
- Line held low for 20 bit times → one frame with data_o = 0x00 and frame_err_o = 1, FSM parks in WAIT_HIGH; after the line returns high, send 0x55 → received clean.
- DATA_BITS = 9, STOP_BITS = 2; send 0x1FF with a 1-cycle glitch inside each bit, and separately assert rst_ni low mid-frame → 0x1FF is still received (majority vote masks the glitch); the reset case gives all outputs 0 and no frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic int cnt_width(input int oversample);
        return (oversample < 2) ? 1 : $clog2(oversample);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser plus three-tap mid-bit capture with majority vote.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int CW         = cnt_width(OVERSAMPLE)
) (
    input  logic          s_clk_i,
    input  logic          rst_ni,
    input  logic          rx_i,
    input  logic [CW-1:0] cnt,
    output logic          rx_s_o,
    output logic          bit_o
);

    localparam logic [CW-1:0] TAP_A = CW'(OVERSAMPLE/2 - 1);
    localparam logic [CW-1:0] TAP_B = CW'(OVERSAMPLE/2);

    logic [1:0] sync_q;
    logic       tap_a_q;
    logic       tap_b_q;

    always_ff @(posedge s_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= 2'b11;
            tap_a_q <= 1'b1;
            tap_b_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], rx_i};
            if (cnt == TAP_A) tap_a_q <= sync_q[1];
            if (cnt == TAP_B) tap_b_q <= sync_q[1];
        end
    end

    assign rx_s_o = sync_q[1];

    // Third tap is the live synchronised line, so the vote is ready in the decision cycle.
    assign bit_o = maj3(tap_a_q, tap_b_q, rx_s_o);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with a one-entry valid/ready holding register.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line high, waiting for a start edge
// START     | start bit; rejected as a glitch if the vote is 1
// DATA      | shifting in DATA_BITS data bits, LSB first
// PARITY    | parity bit checked against the data
// STOP      | stop bit(s); frame completes on the last stop decision
// WAIT_HIGH | last stop sampled low (break); wait for the line to rise
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 s_clk_i,
    input  logic                 rst_ni,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 data_valid_o,
    input  logic                 data_ready_i,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int CW = cnt_width(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_DEC   = CW'(OVERSAMPLE/2 + 1);
    localparam logic [CW-1:0] CNT_WRAP  = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = (STOP_BITS > 1);
    localparam logic          PAR_MODE  = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

    rx_state_t            state_q;
    rx_state_t            state_d;
    logic [CW-1:0]        cnt_q;
    logic [BW-1:0]        bit_idx_q;
    logic                 stop_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 perr_q;
    logic                 ferr_q;

    logic rx_s;
    logic bit_v;
    logic dec;
    logic wrap;
    logic frame_done;

    uart_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE),
        .CW         (CW)
    ) u_sampler (
        .s_clk_i (s_clk_i),
        .rst_ni  (rst_ni),
        .rx_i    (rx_i),
        .cnt     (cnt_q),
        .rx_s_o  (rx_s),
        .bit_o   (bit_v)
    );

    assign dec        = (cnt_q == CNT_DEC);
    assign wrap       = (cnt_q == CNT_WRAP);
    assign frame_done = (state_q == STOP) && dec && (stop_idx_q == LAST_STOP);
    assign busy_o     = (state_q != IDLE);

    always_ff @(posedge s_clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!rx_s) state_d = START;
            end
            START: begin
                if (dec && bit_v) state_d = IDLE;
                else if (wrap)    state_d = DATA;
            end
            DATA: begin
                if (wrap && (bit_idx_q == LAST_BIT))
                    state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: begin
                if (wrap) state_d = STOP;
            end
            STOP: begin
                // Leave at the decision, not the wrap, so a following start edge is caught early.
                if (frame_done) state_d = bit_v ? IDLE : WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge s_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            if ((state_d == IDLE) || (state_d == WAIT_HIGH) || wrap) cnt_q <= '0;
            else                                                     cnt_q <= cnt_q + 1'b1;

            if (state_q != DATA)
                bit_idx_q <= '0;
            else if (wrap)
                bit_idx_q <= (bit_idx_q == LAST_BIT) ? '0 : bit_idx_q + 1'b1;

            if (state_q != STOP) stop_idx_q <= 1'b0;
            else if (wrap)       stop_idx_q <= 1'b1;

            if ((state_q == DATA) && dec)
                shift_q <= {bit_v, shift_q[DATA_BITS-1:1]};

            if (state_q == IDLE)
                perr_q <= 1'b0;
            else if ((state_q == PARITY) && dec)
                perr_q <= ((bit_v ^ (^shift_q)) != PAR_MODE);

            if (state_q == IDLE)
                ferr_q <= 1'b0;
            else if ((state_q == STOP) && dec)
                ferr_q <= ferr_q | ~bit_v;
        end
    end

    always_ff @(posedge s_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_o       <= '0;
            frame_err_o  <= 1'b0;
            parity_err_o <= 1'b0;
            data_valid_o <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (frame_done) begin
                if (!data_valid_o || data_ready_i) begin
                    data_o       <= shift_q;
                    frame_err_o  <= ferr_q | ~bit_v;
                    parity_err_o <= perr_q;
                    data_valid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (data_valid_o && data_ready_i) begin
                data_valid_o <= 1'b0;
            end
        end
    end

endmodule
